control_sequencer: RTL
======================

CONTROL_SEQUENCER -- requirements
Module: control_sequencer

Interface
REQ-001 Parameter CNT_W, default 16, width of the retired-instruction counter.
REQ-002 w_clock  input  1  single clock; all state changes on its rising edge.
REQ-003 w_clear  input  1  reset, synchronous and active-high.
REQ-004 w_run  input  1  level; high permits fetch of the next instruction.
REQ-005 w_mem_ready  input  1  memory read data valid on Mdatain this cycle.
REQ-006 w_IR  input  32  IR contents: op=[31:27], Ra=[26:23], Rb=[22:19], Rc=[18:15].
REQ-007 s_PC, s_Zlow, s_Zhigh, s_MDR  output  1 each  bus source selects.
REQ-008 s_R  output  16  one-hot register bus select; bit n drives Rn.
REQ-009 e_R  output  16  one-hot register write enable; bit n loads Rn.
REQ-010 e_MAR, e_Z, e_PC, e_MDR, e_IR, e_Y, e_HI, e_LO, e_alu  output  1 each  load/compute enables.
REQ-011 w_IncPC, w_read  output  1 each  PC increment request; memory read strobe.
REQ-012 opcode  output  6  ALU operation, {1'b0, op}.
REQ-013 w_busy  output  1  high in every state except IDLE.
REQ-014 w_illegal  output  1  one-cycle pulse on an undefined op.
REQ-015 instr_count  output  CNT_W  count of retired instructions.

Function
REQ-016 The FSM SHALL have states IDLE, T0, T1, T2, T3, T4, T5, T6; outputs SHALL be a Moore decode of the registered state, plus IR fields and w_mem_ready.
REQ-017 At most one bus select (s_PC, s_Zlow, s_Zhigh, s_MDR, any s_R bit) SHALL be high in any cycle.
REQ-018 IDLE -> T0 when w_run=1; else stay in IDLE.
REQ-019 T0 SHALL assert s_PC, e_MAR, w_IncPC, e_Z; next T1.
REQ-020 T1 SHALL assert w_read and e_MDR; it SHALL stay in T1 while w_mem_ready=0; with w_mem_ready=1 it SHALL also assert s_Zlow and e_PC, then go to T2. PC SHALL load exactly once per fetch.
REQ-021 T2 SHALL assert s_MDR and e_IR; next T3. IR fields SHALL be decoded only from T3 onward.
REQ-022 Binary ops (add 0, sub 1, and 2, or 3, rol 7, ror 8, shr 9, shra 10, shl 11):
 - T3: s_R[Rb], e_Y.
 - T4: s_R[Rc], e_alu, e_Z, opcode.
 - T5: s_Zlow, e_R[Ra]; this is the retire cycle.
REQ-023 Unary ops (not 4, neg 12):
 - T3: s_R[Rb], e_alu, e_Z, opcode.
 - T4: s_Zlow, e_R[Ra]; this is the retire cycle.
REQ-024 mul 5 and div 6:
 - T3: s_R[Ra], e_Y.
 - T4: s_R[Rb], e_alu, e_Z, opcode.
 - T5: s_Zlow, e_LO.
 - T6: s_Zhigh, e_HI; this is the retire cycle. No e_R bit SHALL be asserted.
REQ-025 Op 13..31 in T3 SHALL pulse w_illegal, assert no enables, leave instr_count unchanged, and then take the retire-cycle transition.
REQ-026 After a retire cycle the FSM SHALL go to T0 if w_run=1, else to IDLE. Dropping w_run mid-instruction SHALL NOT abort the instruction.
REQ-027 instr_count SHALL increment by 1 at the end of each legal retire cycle and SHALL wrap from 2^CNT_W-1 to 0.
REQ-028 opcode SHALL hold its last value outside ALU cycles. All other outputs SHALL be 0 in any cycle not listed above.

Reset
REQ-029 When w_clear=1 at a rising edge, the FSM SHALL go to IDLE, clear instr_count, and clear the held opcode, regardless of state (including T1 wait and mid-T6).
REQ-030 While in reset and in IDLE, all enables, selects, w_read, w_IncPC, w_busy and w_illegal SHALL be 0.
REQ-031 The first fetch after reset is released SHALL start at T0 on the first edge with w_run=1.

Verification
REQ-032 Case 1: w_IR=0x10918000 (and R1,R2,R3), w_mem_ready=1.
 - Required: T3 s_R=0x0004 with e_Y; T4 s_R=0x0008 with opcode=2; T5 e_R=0x0002.
 - Required: exactly 6 busy cycles; instr_count=1.
REQ-033 Case 2: w_IR=0x40918000 (ror), w_mem_ready low for 3 cycles.
 - Required: T1 held for 4 cycles; e_PC high only in the last of them; opcode=8 in T4.
REQ-034 Case 3: w_IR=0x29180000 (mul R2,R3).
 - Required: T3 s_R=0x0004; T4 s_R=0x0008 with opcode=5; T5 e_LO; T6 s_Zhigh with e_HI; e_R=0 throughout.
REQ-035 Case 4: w_IR=0x60900000 (neg R1,R2).
 - Required: T3 s_R=0x0004 with e_alu and opcode=12; T4 e_R=0x0002; 5 busy cycles.
REQ-036 Case 5: w_IR=0xF8000000.
 - Required: w_illegal high for exactly 1 cycle in T3; instr_count unchanged; return to T0 with w_run=1.
REQ-037 Case 6: w_clear=1 during T4 of an add.
 - Required: next cycle IDLE with all outputs 0; instr_count=0; with w_run=1 the next fetch starts at T0.

Source files
------------

// File: rtl/control_sequencer.sv
// Control unit: fetches an instruction through T0..T2, then runs a per-class
// micro-sequence in T3..T6 and counts each legally retired instruction.
module control_sequencer #(
   parameter int CNT_W = 16
) (
   input  logic             w_clock,
   input  logic             w_clear,
   input  logic             w_run,
   input  logic             w_mem_ready,
   input  logic [31:0]      w_IR,
   output logic             s_PC,
   output logic             s_Zlow,
   output logic             s_Zhigh,
   output logic             s_MDR,
   output logic [15:0]      s_R,
   output logic [15:0]      e_R,
   output logic             e_MAR,
   output logic             e_Z,
   output logic             e_PC,
   output logic             e_MDR,
   output logic             e_IR,
   output logic             e_Y,
   output logic             e_HI,
   output logic             e_LO,
   output logic             e_alu,
   output logic             w_IncPC,
   output logic             w_read,
   output logic [5:0]       opcode,
   output logic             w_busy,
   output logic             w_illegal,
   output logic [CNT_W-1:0] instr_count,
   output logic [2:0]       o_dbg_state
);

   // Debug encoding: IDLE=0, T0..T6 = 1..7.
   typedef enum logic [2:0] {
      ST_IDLE = 3'd0, ST_T0 = 3'd1, ST_T1 = 3'd2, ST_T2 = 3'd3,
      ST_T3   = 3'd4, ST_T4 = 3'd5, ST_T5 = 3'd6, ST_T6 = 3'd7
   } state_t;

   state_t           r_state;
   state_t           w_next;
   logic [5:0]       r_opcode;
   logic [CNT_W-1:0] r_count;

   logic [4:0] w_op;
   logic [3:0] w_ra, w_rb, w_rc;
   logic       w_is_un, w_is_md, w_is_ill;
   logic       w_alu_cycle;
   logic       w_count_en;
   logic       w_unused;
   state_t     w_after_retire;

   assign w_op     = w_IR[31:27];
   assign w_ra     = w_IR[26:23];
   assign w_rb     = w_IR[22:19];
   assign w_rc     = w_IR[18:15];
   assign w_unused = ^w_IR[14:0];

   // Anything not unary, mul/div or illegal is a two-operand ALU op.
   assign w_is_un  = (w_op == 5'd4) || (w_op == 5'd12);
   assign w_is_md  = (w_op == 5'd5) || (w_op == 5'd6);
   assign w_is_ill = (w_op >= 5'd13);

   assign w_after_retire = w_run ? ST_T0 : ST_IDLE;

   // Legal instructions only ever retire in T4, T5 or T6.
   assign w_count_en = ((r_state == ST_T4) && w_is_un) ||
                       ((r_state == ST_T5) && !w_is_md && !w_is_un) ||
                       (r_state == ST_T6);

   always_ff @(posedge w_clock) begin
      if (w_clear) begin
         r_state  <= ST_IDLE;
         r_opcode <= 6'd0;
         r_count  <= '0;
      end else begin
         r_state  <= w_next;
         r_opcode <= opcode;
         if (w_count_en) r_count <= r_count + CNT_W'(1);
      end
   end

   always_comb begin
      w_next = r_state;
      case (r_state)
         ST_IDLE: w_next = w_run ? ST_T0 : ST_IDLE;
         ST_T0:   w_next = ST_T1;
         ST_T1:   w_next = w_mem_ready ? ST_T2 : ST_T1;
         ST_T2:   w_next = ST_T3;
         ST_T3:   w_next = w_is_ill ? w_after_retire : ST_T4;
         ST_T4:   w_next = w_is_un ? w_after_retire : ST_T5;
         ST_T5:   w_next = w_is_md ? ST_T6 : w_after_retire;
         ST_T6:   w_next = w_after_retire;
         default: w_next = ST_IDLE;
      endcase
   end

   always_comb begin
      s_PC = 1'b0; s_Zlow = 1'b0; s_Zhigh = 1'b0; s_MDR = 1'b0;
      s_R = 16'd0; e_R = 16'd0;
      e_MAR = 1'b0; e_Z = 1'b0; e_PC = 1'b0; e_MDR = 1'b0; e_IR = 1'b0;
      e_Y = 1'b0; e_HI = 1'b0; e_LO = 1'b0; e_alu = 1'b0;
      w_IncPC = 1'b0; w_read = 1'b0; w_illegal = 1'b0;
      w_alu_cycle = 1'b0;
      case (r_state)
         ST_T0: begin
            s_PC = 1'b1; e_MAR = 1'b1; w_IncPC = 1'b1; e_Z = 1'b1;
         end
         ST_T1: begin
            w_read = 1'b1; e_MDR = 1'b1;
            if (w_mem_ready) begin
               s_Zlow = 1'b1; e_PC = 1'b1;
            end
         end
         ST_T2: begin
            s_MDR = 1'b1; e_IR = 1'b1;
         end
         ST_T3: begin
            if (w_is_ill) begin
               w_illegal = 1'b1;
            end else if (w_is_un) begin
               s_R = 16'd1 << w_rb; e_alu = 1'b1; e_Z = 1'b1; w_alu_cycle = 1'b1;
            end else begin
               s_R = 16'd1 << (w_is_md ? w_ra : w_rb); e_Y = 1'b1;
            end
         end
         ST_T4: begin
            if (w_is_un) begin
               s_Zlow = 1'b1; e_R = 16'd1 << w_ra;
            end else begin
               s_R = 16'd1 << (w_is_md ? w_rb : w_rc);
               e_alu = 1'b1; e_Z = 1'b1; w_alu_cycle = 1'b1;
            end
         end
         ST_T5: begin
            s_Zlow = 1'b1;
            if (w_is_md) e_LO = 1'b1;
            else         e_R  = 16'd1 << w_ra;
         end
         ST_T6: begin
            s_Zhigh = 1'b1; e_HI = 1'b1;
         end
         default: ;
      endcase
   end

   // The ALU opcode is live only while the ALU computes; otherwise it holds.
   assign opcode      = w_alu_cycle ? {1'b0, w_op} : r_opcode;
   assign w_busy      = (r_state != ST_IDLE);
   assign instr_count = r_count;
   assign o_dbg_state = r_state;

endmodule
